// File: rtl/hex_output_pager_pkg.sv
// Shared definitions for the hex output pager: state codes, seven-segment
// font, dark pattern and page-count/nibble-select helpers.
package hex_output_pager_pkg;

  // Controller state encodings (4-bit, legacy numeric values kept stable)
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_CAPTURE   = 4'd1;
  localparam logic [3:0] ST_SHOW      = 4'd2;
  localparam logic [3:0] ST_STEP_FWD  = 4'd3;
  localparam logic [3:0] ST_STEP_BACK = 4'd4;
  localparam logic [3:0] ST_NEXT_HELD = 4'd5;
  localparam logic [3:0] ST_PREV_HELD = 4'd6;
  localparam logic [3:0] ST_CLEAR     = 4'd7;

  // All segments off, expressed in active-high polarity
  localparam logic [6:0] SEG_DARK_AH = 7'h00;

  // Default geometry: four displays give four pages of four nibbles
  localparam int DISP_DIGITS_DEFAULT = 4;
  localparam int PAGES_DEFAULT       = 16 / DISP_DIGITS_DEFAULT;

  // Number of pages needed to walk all 16 nibbles with a given display count
  function automatic int pages_for(input int digits);
    return 16 / digits;
  endfunction

  // Active-high gfedcba font for one hex nibble
  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = SEG_DARK_AH;
    endcase
    return seg;
  endfunction

  // Nibble idx counted from the MSB end (idx 0 = bits 63:60).
  // Top bit of nibble idx is 63-4*idx = {~idx, 2'b11}.
  function automatic logic [3:0] pick_nibble(input logic [63:0] word, input logic [3:0] idx);
    return word[{~idx, 2'b11} -: 4];
  endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// One seven-segment digit: nibble -> gfedcba pattern with blanking and
// selectable pin polarity.
module hex_to_seven_seg
  import hex_output_pager_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_ah_s;

  // Decode nibble to active-high segments, then apply board polarity
  always_comb begin
    seg_ah_s = SEG_DARK_AH;
    if (blank_i) begin
      seg_ah_s = SEG_DARK_AH;
    end else begin
      seg_ah_s = seg_font(nibble_i);
    end
    if (SEG_ACTIVE_LOW) begin
      seg_o = ~seg_ah_s;
    end else begin
      seg_o = seg_ah_s;
    end
  end

endmodule

// File: rtl/hex_output_pager.sv
// Latches a 64-bit result and pages its 16 hex nibbles across DISP_DIGITS
// seven-segment displays under next/prev/clear push-button control.
module hex_output_pager
  import hex_output_pager_pkg::*;
#(
  parameter int DISP_DIGITS    = DISP_DIGITS_DEFAULT,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              values,
  input  logic                     resultReady,
  input  logic                     nextButton,
  input  logic                     prevButton,
  input  logic                     clear,
  output logic [7*DISP_DIGITS-1:0] segs,
  output logic [4:0]               page,
  output logic                     showing,
  output logic [3:0]               S
);

  localparam int         PAGES     = pages_for(DISP_DIGITS);
  localparam logic [4:0] PAGE_STEP = 5'(DISP_DIGITS);
  // Leftmost-nibble index of the final page; stepping forward saturates here
  localparam logic [4:0] LAST_PAGE = 5'((PAGES - 1) * DISP_DIGITS);

  logic [3:0]  s_q, s_d;
  logic [63:0] held_q, held_d;
  logic [4:0]  page_q, page_d;
  logic        showing_s;

  // Next-state logic: state walk, result capture and page stepping
  always_comb begin
    s_d    = s_q;
    held_d = held_q;
    page_d = page_q;
    case (s_q)
      ST_IDLE: begin
        if (resultReady) begin
          held_d = values;
          s_d    = ST_CAPTURE;
        end else begin
          s_d    = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        // A strobe landing here still replaces the held word
        if (resultReady) begin
          held_d = values;
        end else begin
          held_d = held_q;
        end
        page_d = 5'd0;
        s_d    = ST_SHOW;
      end
      ST_SHOW: begin
        if (resultReady) begin
          held_d = values;
          s_d    = ST_CAPTURE;
        end else if (!nextButton) begin
          s_d = ST_STEP_FWD;
        end else if (!prevButton) begin
          s_d = ST_STEP_BACK;
        end else if (!clear) begin
          s_d = ST_CLEAR;
        end else begin
          s_d = ST_SHOW;
        end
      end
      ST_STEP_FWD: begin
        if (resultReady) begin
          held_d = values;
          page_d = 5'd0;
        end else if (page_q != LAST_PAGE) begin
          page_d = page_q + PAGE_STEP;
        end else begin
          page_d = page_q;
        end
        s_d = ST_NEXT_HELD;
      end
      ST_STEP_BACK: begin
        if (resultReady) begin
          held_d = values;
          page_d = 5'd0;
        end else if (page_q != 5'd0) begin
          page_d = page_q - PAGE_STEP;
        end else begin
          page_d = page_q;
        end
        s_d = ST_PREV_HELD;
      end
      ST_NEXT_HELD: begin
        if (resultReady) begin
          held_d = values;
          page_d = 5'd0;
        end else begin
          held_d = held_q;
        end
        if (nextButton) begin
          s_d = ST_SHOW;
        end else begin
          s_d = ST_NEXT_HELD;
        end
      end
      ST_PREV_HELD: begin
        if (resultReady) begin
          held_d = values;
          page_d = 5'd0;
        end else begin
          held_d = held_q;
        end
        if (prevButton) begin
          s_d = ST_SHOW;
        end else begin
          s_d = ST_PREV_HELD;
        end
      end
      ST_CLEAR: begin
        held_d = 64'd0;
        page_d = 5'd0;
        s_d    = ST_IDLE;
      end
      default: begin
        s_d = ST_IDLE;
      end
    endcase
  end

  // State, held word and page registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q    <= ST_IDLE;
      held_q <= 64'd0;
      page_q <= 5'd0;
    end else begin
      s_q    <= s_d;
      held_q <= held_d;
      page_q <= page_d;
    end
  end

  // Displays are lit in every state that presents a held value
  always_comb begin
    case (s_q)
      ST_CAPTURE, ST_SHOW, ST_STEP_FWD, ST_STEP_BACK,
      ST_NEXT_HELD, ST_PREV_HELD: showing_s = 1'b1;
      default:                    showing_s = 1'b0;
    endcase
  end

  // One decoder per display; d = DISP_DIGITS-1 is leftmost and shows nibble 'page'
  for (genvar d = 0; d < DISP_DIGITS; d++) begin : g_digit
    logic [3:0] nib_idx_s;
    logic [3:0] nibble_s;
    logic [6:0] seg_s;

    assign nib_idx_s = page_q[3:0] + 4'(DISP_DIGITS - 1 - d);
    assign nibble_s  = pick_nibble(held_q, nib_idx_s);

    hex_to_seven_seg #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
      .nibble_i(nibble_s),
      .blank_i (~showing_s),
      .seg_o   (seg_s)
    );

    assign segs[7*d +: 7] = seg_s;
  end

  assign page    = page_q;
  assign showing = showing_s;
  assign S       = s_q;

endmodule

// File: tb/tb_hex_output_pager.sv
// Directed bench for hex_output_pager (DISP_DIGITS=4, active-low segments).
module tb_hex_output_pager;

  logic        clk;
  logic        rst;
  logic [63:0] values;
  logic        resultReady;
  logic        nextButton;
  logic        prevButton;
  logic        clear;
  logic [27:0] segs;
  logic [4:0]  page;
  logic        showing;
  logic [3:0]  S;

  int n_vec;
  int n_err;

  localparam logic [27:0] SEGS_DARK = 28'hFFFFFFF;
  localparam logic [27:0] SEGS_0123 = {7'h40, 7'h79, 7'h24, 7'h30};
  localparam logic [27:0] SEGS_4567 = {7'h19, 7'h12, 7'h02, 7'h78};
  localparam logic [27:0] SEGS_89AB = {7'h00, 7'h10, 7'h08, 7'h03};
  localparam logic [27:0] SEGS_CDEF = {7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [27:0] SEGS_FFFF = {7'h0E, 7'h0E, 7'h0E, 7'h0E};

  hex_output_pager #(
    .DISP_DIGITS   (4),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .values     (values),
    .resultReady(resultReady),
    .nextButton (nextButton),
    .prevButton (prevButton),
    .clear      (clear),
    .segs       (segs),
    .page       (page),
    .showing    (showing),
    .S          (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press a button line low for hold_cycles edges, then release and let the FSM return to SHOW
  task automatic press_next(input int hold_cycles);
    nextButton = 1'b0;
    repeat (hold_cycles) step();
    nextButton = 1'b1;
    step();
  endtask

  task automatic press_prev(input int hold_cycles);
    prevButton = 1'b0;
    repeat (hold_cycles) step();
    prevButton = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; nextButton = 1'b0; prevButton = 1'b0; clear = 1'b0;
    resultReady = 1'b0; values = 64'd0;
    step(); step();
    n_vec++; if (S !== 4'd0)       begin n_err++; $display("FAIL reset_S got %0d want 0", S); end
    n_vec++; if (page !== 5'd0)    begin n_err++; $display("FAIL reset_page got %0d want 0", page); end
    n_vec++; if (showing !== 1'b0) begin n_err++; $display("FAIL reset_showing got %b want 0", showing); end
    n_vec++; if (segs !== SEGS_DARK) begin n_err++; $display("FAIL reset_segs got %h want %h", segs, SEGS_DARK); end
    nextButton = 1'b1; prevButton = 1'b1; clear = 1'b1; rst = 1'b1;
    step();
    n_vec++; if (S !== 4'd0) begin n_err++; $display("FAIL idle_hold_S got %0d want 0", S); end
  endtask

  task automatic test_capture(input logic [63:0] word, input logic [27:0] exp_segs);
    values = word; resultReady = 1'b1;
    step();
    resultReady = 1'b0; values = 64'd0;
    n_vec++; if (S !== 4'd1) begin n_err++; $display("FAIL capture_S1 got %0d want 1", S); end
    step();
    n_vec++; if (S !== 4'd2)         begin n_err++; $display("FAIL capture_S2 got %0d want 2", S); end
    n_vec++; if (page !== 5'd0)      begin n_err++; $display("FAIL capture_page got %0d want 0", page); end
    n_vec++; if (showing !== 1'b1)   begin n_err++; $display("FAIL capture_showing got %b want 1", showing); end
    n_vec++; if (segs !== exp_segs)  begin n_err++; $display("FAIL capture_segs got %h want %h", segs, exp_segs); end
  endtask

  task automatic test_paging();
    logic [4:0]  exp_page [4];
    logic [27:0] exp_segs [4];
    exp_page[0] = 5'd4;  exp_segs[0] = SEGS_4567;
    exp_page[1] = 5'd8;  exp_segs[1] = SEGS_89AB;
    exp_page[2] = 5'd12; exp_segs[2] = SEGS_CDEF;
    exp_page[3] = 5'd12; exp_segs[3] = SEGS_CDEF;
    for (int i = 0; i < 4; i++) begin
      press_next(5);
      n_vec++; if (page !== exp_page[i]) begin n_err++; $display("FAIL page_next%0d got %0d want %0d", i, page, exp_page[i]); end
      n_vec++; if (segs !== exp_segs[i]) begin n_err++; $display("FAIL segs_next%0d got %h want %h", i, segs, exp_segs[i]); end
      n_vec++; if (S !== 4'd2) begin n_err++; $display("FAIL S_next%0d got %0d want 2", i, S); end
    end
    press_prev(5);
    n_vec++; if (page !== 5'd8)      begin n_err++; $display("FAIL page_prev got %0d want 8", page); end
    n_vec++; if (segs !== SEGS_89AB) begin n_err++; $display("FAIL segs_prev got %h want %h", segs, SEGS_89AB); end
  endtask

  task automatic test_held_button();
    press_prev(5);
    n_vec++; if (page !== 5'd4) begin n_err++; $display("FAIL held_pre_page got %0d want 4", page); end
    nextButton = 1'b0;
    repeat (50) step();
    n_vec++; if (page !== 5'd8) begin n_err++; $display("FAIL held_page got %0d want 8", page); end
    n_vec++; if (S !== 4'd5)    begin n_err++; $display("FAIL held_S got %0d want 5", S); end
    nextButton = 1'b1;
    step();
    n_vec++; if (S !== 4'd2)    begin n_err++; $display("FAIL held_release_S got %0d want 2", S); end
    n_vec++; if (page !== 5'd8) begin n_err++; $display("FAIL held_release_page got %0d want 8", page); end
  endtask

  task automatic test_override();
    press_prev(5);
    nextButton = 1'b0;
    step(); step();
    n_vec++; if (S !== 4'd5)    begin n_err++; $display("FAIL ovr_pre_S got %0d want 5", S); end
    n_vec++; if (page !== 5'd8) begin n_err++; $display("FAIL ovr_pre_page got %0d want 8", page); end
    values = 64'hFFFF_FFFF_FFFF_FFFF; resultReady = 1'b1;
    step();
    resultReady = 1'b0; values = 64'd0;
    n_vec++; if (page !== 5'd0) begin n_err++; $display("FAIL ovr_page got %0d want 0", page); end
    n_vec++; if (S !== 4'd5)    begin n_err++; $display("FAIL ovr_S got %0d want 5", S); end
    nextButton = 1'b1;
    step();
    n_vec++; if (S !== 4'd2)         begin n_err++; $display("FAIL ovr_release_S got %0d want 2", S); end
    n_vec++; if (segs !== SEGS_FFFF) begin n_err++; $display("FAIL ovr_segs got %h want %h", segs, SEGS_FFFF); end
  endtask

  task automatic test_clear();
    clear = 1'b0;
    step();
    n_vec++; if (S !== 4'd7)         begin n_err++; $display("FAIL clear_S got %0d want 7", S); end
    n_vec++; if (showing !== 1'b0)   begin n_err++; $display("FAIL clear_showing got %b want 0", showing); end
    n_vec++; if (segs !== SEGS_DARK) begin n_err++; $display("FAIL clear_segs got %h want %h", segs, SEGS_DARK); end
    step();
    clear = 1'b1;
    n_vec++; if (S !== 4'd0)    begin n_err++; $display("FAIL clear_idle_S got %0d want 0", S); end
    n_vec++; if (page !== 5'd0) begin n_err++; $display("FAIL clear_idle_page got %0d want 0", page); end
    step();
    n_vec++; if (segs !== SEGS_DARK) begin n_err++; $display("FAIL clear_idle_segs got %h want %h", segs, SEGS_DARK); end
  endtask

  task automatic test_mid_reset();
    press_next(3);
    press_next(3);
    prevButton = 1'b0;
    step(); step();
    n_vec++; if (S !== 4'd6)    begin n_err++; $display("FAIL mrst_pre_S got %0d want 6", S); end
    n_vec++; if (page !== 5'd4) begin n_err++; $display("FAIL mrst_pre_page got %0d want 4", page); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_vec++; if (S !== 4'd0)         begin n_err++; $display("FAIL mrst_S got %0d want 0", S); end
    n_vec++; if (page !== 5'd0)      begin n_err++; $display("FAIL mrst_page got %0d want 0", page); end
    n_vec++; if (segs !== SEGS_DARK) begin n_err++; $display("FAIL mrst_segs got %h want %h", segs, SEGS_DARK); end
    step();
    n_vec++; if (S !== 4'd0) begin n_err++; $display("FAIL mrst_stay_S got %0d want 0", S); end
    prevButton = 1'b1;
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_capture(64'h0123_4567_89AB_CDEF, SEGS_0123);
    test_paging();
    test_held_button();
    test_override();
    test_clear();
    test_capture(64'h0123_4567_89AB_CDEF, SEGS_0123);
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
